// File: rtl/cache_fill_ctrl_if.sv
// Requester, memory bus and RAM write-port signals of the cache fill controller.
// master: the controller side. slave: the environment side (requester, bus, RAMs).
interface cache_fill_ctrl_if #(
    parameter int unsigned cache_size      = 8192,
    parameter int unsigned cache_line_size = 32
);
    localparam int unsigned nr_lines       = cache_size / cache_line_size;
    localparam int unsigned data_addr_bits = $clog2(cache_size / 4);
    localparam int unsigned index_bits     = $clog2(nr_lines);
    localparam int unsigned offset_bits    = $clog2(cache_line_size);
    localparam int unsigned tag_bits       = 32 - index_bits - offset_bits;

    // Requester
    logic                      miss;
    logic [31:0]               miss_addr;
    logic                      inval;
    logic                      busy;
    logic                      done;
    logic                      fill_error;
    // Memory bus
    logic                      m_access;
    logic [31:0]               m_addr;
    logic                      m_ack;
    logic                      m_error;
    logic [31:0]               m_data;
    // Data RAM write port
    logic                      dram_wr_en;
    logic [data_addr_bits-1:0] dram_write_addr;
    logic [31:0]               dram_write_data;
    logic [3:0]                dram_bytesel;
    // Tag RAM write port
    logic                      tag_wr_en;
    logic [index_bits-1:0]     tag_index;
    logic [tag_bits-1:0]       tag_value;
    logic                      tag_valid;

    modport master (
        input  miss, miss_addr, inval, m_ack, m_error, m_data,
        output busy, done, fill_error, m_access, m_addr,
        output dram_wr_en, dram_write_addr, dram_write_data, dram_bytesel,
        output tag_wr_en, tag_index, tag_value, tag_valid
    );

    modport slave (
        output miss, miss_addr, inval, m_ack, m_error, m_data,
        input  busy, done, fill_error, m_access, m_addr,
        input  dram_wr_en, dram_write_addr, dram_write_data, dram_bytesel,
        input  tag_wr_en, tag_index, tag_value, tag_valid
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Line fill and invalidate-all sequencer for a direct-mapped cache.
// A fill invalidates the line's tag, streams one line from the bus word by word into the
// data RAM (writes registered one cycle behind each ack), then commits the tag as valid.
// An invalidate walks every tag index clearing valid, one index per cycle.
module cache_fill_ctrl #(
    parameter int unsigned cache_size      = 8192,
    parameter int unsigned cache_line_size = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_fill_ctrl_if.master bus
);
    localparam int unsigned words_per_line = cache_line_size / 4;
    localparam int unsigned nr_lines       = cache_size / cache_line_size;
    localparam int unsigned data_addr_bits = $clog2(cache_size / 4);
    localparam int unsigned index_bits     = $clog2(nr_lines);
    localparam int unsigned offset_bits    = $clog2(cache_line_size);
    localparam int unsigned tag_bits       = 32 - index_bits - offset_bits;
    localparam int unsigned word_bits      = offset_bits - 2;
    localparam int unsigned line_bits      = 32 - offset_bits;

    typedef enum logic [1:0] {StIdle, StFill, StCommit, StFlush} state_e;

    state_e                    state_q, state_d;
    logic [word_bits-1:0]      word_cnt_q, word_cnt_d;
    logic [index_bits-1:0]     flush_cnt_q, flush_cnt_d;
    logic [line_bits-1:0]      line_q, line_d;       // tag and index of the line being filled
    logic                      first_q, first_d;     // FILL entry cycle
    logic                      err_q, err_d;         // fill aborted on a bus error
    logic                      wr_pend_q, wr_pend_d; // data RAM write due this cycle
    logic [data_addr_bits-1:0] waddr_q, waddr_d;
    logic [31:0]               wdata_q, wdata_d;

    logic [index_bits-1:0]     line_index;
    logic [tag_bits-1:0]       line_tag;
    logic                      unused_offset;

    assign line_index    = line_q[index_bits-1:0];
    assign line_tag      = line_q[line_bits-1:index_bits];
    assign unused_offset = ^bus.miss_addr[offset_bits-1:0];

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            word_cnt_q  <= '0;
            flush_cnt_q <= '0;
            line_q      <= '0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
            wr_pend_q   <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            line_q      <= line_d;
            first_q     <= first_d;
            err_q       <= err_d;
            wr_pend_q   <= wr_pend_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next-state: request arbitration, word/flush counting and capture of acked bus data.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        flush_cnt_d = flush_cnt_q;
        line_d      = line_q;
        first_d     = 1'b0;
        err_d       = err_q;
        wr_pend_d   = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        unique case (state_q)
            StIdle: begin
                // inval wins; a simultaneous miss stays pending until the flush is done
                if (bus.inval) begin
                    state_d = StFlush;
                end else if (bus.miss) begin
                    state_d = StFill;
                    line_d  = bus.miss_addr[31:offset_bits];
                    first_d = 1'b1;
                    err_d   = 1'b0;
                end
            end
            StFill: begin
                if (bus.m_ack) begin
                    if (bus.m_error) begin
                        state_d    = StCommit;
                        err_d      = 1'b1;
                        word_cnt_d = '0;
                    end else begin
                        wr_pend_d  = 1'b1;
                        wdata_d    = bus.m_data;
                        waddr_d    = {line_index, word_cnt_q};
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_q == word_bits'(words_per_line - 1)) begin
                            state_d = StCommit;
                        end
                    end
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            StFlush: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == index_bits'(nr_lines - 1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: all zero in IDLE; RAM write ports driven only while strobed.
    always_comb begin
        bus.busy            = (state_q != StIdle);
        bus.done            = 1'b0;
        bus.fill_error      = 1'b0;
        bus.m_access        = 1'b0;
        bus.m_addr          = '0;
        bus.dram_wr_en      = wr_pend_q;
        bus.dram_write_addr = wr_pend_q ? waddr_q : '0;
        bus.dram_write_data = wr_pend_q ? wdata_q : '0;
        bus.dram_bytesel    = wr_pend_q ? 4'hf : 4'h0;
        bus.tag_wr_en       = 1'b0;
        bus.tag_index       = '0;
        bus.tag_value       = '0;
        bus.tag_valid       = 1'b0;
        unique case (state_q)
            StFill: begin
                bus.m_access = 1'b1;
                bus.m_addr   = {line_q, word_cnt_q, 2'b00};
                // invalidate first so a partially written line can never hit
                if (first_q) begin
                    bus.tag_wr_en = 1'b1;
                    bus.tag_index = line_index;
                end
            end
            StCommit: begin
                bus.done       = 1'b1;
                bus.fill_error = err_q;
                if (!err_q) begin
                    bus.tag_wr_en = 1'b1;
                    bus.tag_index = line_index;
                    bus.tag_value = line_tag;
                    bus.tag_valid = 1'b1;
                end
            end
            StFlush: begin
                bus.tag_wr_en = 1'b1;
                bus.tag_index = flush_cnt_q;
                bus.done      = (flush_cnt_q == index_bits'(nr_lines - 1));
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized bench for cache_fill_ctrl: a bus responder with programmable ack spacing and
// error injection, a monitor that logs every RAM write and bus ack, and per-operation
// expectations derived from the fill/flush rules (address arithmetic and cycle counts).
module tb_cache_fill_ctrl;
    localparam int unsigned CacheSize    = 8192;
    localparam int unsigned LineSize     = 32;
    localparam int unsigned NrLines      = CacheSize / LineSize;
    localparam int unsigned WordsPerLine = LineSize / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_fill_ctrl_if #(.cache_size(CacheSize), .cache_line_size(LineSize)) bus ();

    cache_fill_ctrl #(.cache_size(CacheSize), .cache_line_size(LineSize)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus responder: after seeing m_access for a cycle, acks every gap+1 cycles.
    int unsigned gap      = 0;
    int          err_word = -1;
    int          ack_idx  = 0;
    int unsigned gap_cnt  = 0;
    logic        prev_access = 1'b0;
    logic [31:0] exp_data_q[$];

    always @(posedge clk) begin
        #1;
        bus.m_data  = $urandom;
        bus.m_ack   = 1'b0;
        bus.m_error = 1'b0;
        if (bus.m_access && prev_access) begin
            if (gap_cnt == 0) begin
                bus.m_ack   = 1'b1;
                bus.m_error = (ack_idx == err_word);
                if (!bus.m_error) exp_data_q.push_back(bus.m_data);
                ack_idx++;
                gap_cnt = gap;
            end else begin
                gap_cnt--;
            end
        end else begin
            gap_cnt = gap;
        end
        prev_access = bus.m_access;
    end

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    int          busy_cycles, done_cnt, ferr_cnt, align_err, bytesel_err;
    logic        prev_good;
    logic [10:0] dwa_q[$];
    logic [31:0] dwd_q[$];
    logic [31:0] maddr_q[$];
    logic [7:0]  ti_q[$];
    logic [18:0] tv_q[$];
    logic        tval_q[$];

    always @(negedge clk) begin
        if (bus.busy) busy_cycles++;
        if (bus.done) done_cnt++;
        if (bus.fill_error) ferr_cnt++;
        if (bus.dram_wr_en) begin
            dwa_q.push_back(bus.dram_write_addr);
            dwd_q.push_back(bus.dram_write_data);
            if (!prev_good) align_err++;
            if (bus.dram_bytesel != 4'hf) bytesel_err++;
        end else if (prev_good) begin
            align_err++;
        end
        if (bus.tag_wr_en) begin
            ti_q.push_back(bus.tag_index);
            tv_q.push_back(bus.tag_value);
            tval_q.push_back(bus.tag_valid);
        end
        if (bus.m_ack && bus.m_access) maddr_q.push_back(bus.m_addr);
        prev_good = bus.m_access && bus.m_ack && !bus.m_error;
    end

    task automatic clear_mon();
        busy_cycles = 0; done_cnt = 0; ferr_cnt = 0; align_err = 0; bytesel_err = 0;
        prev_good = 1'b0; ack_idx = 0;
        dwa_q.delete(); dwd_q.delete(); maddr_q.delete();
        ti_q.delete(); tv_q.delete(); tval_q.delete(); exp_data_q.delete();
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctrl"}, {bus.busy, bus.done, bus.fill_error, bus.m_access,
                                  bus.dram_wr_en, bus.tag_wr_en, bus.tag_valid}, 0);
        check_eq({tag, "_maddr"}, bus.m_addr, 0);
        check_eq({tag, "_dram"}, {bus.dram_write_addr, bus.dram_bytesel, bus.dram_write_data}, 0);
        check_eq({tag, "_tag"}, {bus.tag_index, bus.tag_value}, 0);
    endtask

    // Expected outcome of one fill from the line address, ack spacing and error word.
    task automatic check_fill(input logic [31:0] addr, input int gap_v, input int err_v);
        logic [7:0]  idx  = addr[12:5];
        logic [18:0] tag  = addr[31:13];
        logic [31:0] base = {addr[31:5], 5'b0};
        int nacks = (err_v >= 0) ? err_v + 1 : WordsPerLine;
        int ngood = (err_v >= 0) ? err_v : WordsPerLine;
        check_eq("fill_done_count", done_cnt, 1);
        check_eq("fill_error_count", ferr_cnt, (err_v >= 0) ? 1 : 0);
        check_eq("fill_busy_cycles", busy_cycles, nacks * (gap_v + 1) + 2);
        check_eq("fill_dram_writes", dwa_q.size(), ngood);
        for (int k = 0; k < dwa_q.size() && k < ngood && k < exp_data_q.size(); k++) begin
            check_eq("fill_dram_addr", dwa_q[k], {idx, 3'(k)});
            check_eq("fill_dram_data", dwd_q[k], exp_data_q[k]);
        end
        check_eq("fill_ack_count", maddr_q.size(), nacks);
        for (int k = 0; k < maddr_q.size() && k < nacks; k++) begin
            check_eq("fill_m_addr", maddr_q[k], base + 32'(4 * k));
        end
        check_eq("fill_write_align", align_err, 0);
        check_eq("fill_bytesel", bytesel_err, 0);
        check_eq("fill_tag_writes", ti_q.size(), (err_v >= 0) ? 1 : 2);
        if (ti_q.size() >= 1) begin
            check_eq("fill_tag_inval", {ti_q[0], tval_q[0]}, {idx, 1'b0});
        end
        if (err_v < 0 && ti_q.size() >= 2) begin
            check_eq("fill_tag_commit", {ti_q[1], tv_q[1], tval_q[1]}, {idx, tag, 1'b1});
        end
    endtask

    task automatic check_flush();
        int nvalid = 0;
        check_eq("flush_done_count", done_cnt, 1);
        check_eq("flush_busy_cycles", busy_cycles, NrLines);
        check_eq("flush_tag_writes", ti_q.size(), NrLines);
        for (int i = 0; i < ti_q.size() && i < NrLines; i++) begin
            check_eq("flush_index", ti_q[i], i);
            if (tval_q[i]) nvalid++;
        end
        check_eq("flush_valid_set", nvalid, 0);
        check_eq("flush_no_bus", {dwa_q.size(), maddr_q.size()}, 0);
    endtask

    // Requester side: hold miss until done, then drop it.
    task automatic finish_fill(input logic [31:0] addr, input int gap_v, input int err_v);
        bit ok;
        wait_done(400, ok);
        check_eq("fill_done_seen", ok, 1);
        @(posedge clk); #2;
        bus.miss = 1'b0;
        check_fill(addr, gap_v, err_v);
        @(negedge clk);
        check_eq("fill_idle_after", bus.busy, 0);
    endtask

    task automatic run_fill(input logic [31:0] addr, input int gap_v, input int err_v);
        @(posedge clk); #2;
        clear_mon();
        gap = gap_v; err_word = err_v;
        bus.miss_addr = addr;
        bus.miss = 1'b1;
        finish_fill(addr, gap_v, err_v);
    endtask

    task automatic run_flush();
        bit ok;
        @(posedge clk); #2;
        clear_mon();
        bus.inval = 1'b1;
        wait_done(NrLines + 20, ok);
        check_eq("flush_done_seen", ok, 1);
        @(posedge clk); #2;
        bus.inval = 1'b0;
        check_flush();
        @(negedge clk);
        check_eq("flush_idle_after", bus.busy, 0);
    endtask

    initial begin
        bit ok;
        logic [31:0] a;
        bus.miss = 1'b1; bus.miss_addr = 32'h0000_1234; bus.inval = 1'b0;
        bus.m_ack = 1'b0; bus.m_error = 1'b0; bus.m_data = '0;
        clear_mon();

        // Reset held with miss asserted: everything quiet.
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #2;
        clear_mon();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("release_idle_busy", bus.busy, 0);
        @(negedge clk);
        check_eq("release_fill_start", {bus.busy, bus.tag_wr_en, bus.tag_index}, {2'b11, 8'h91});
        finish_fill(32'h0000_1234, 0, -1);

        // Spaced acks, then a bus error on the 4th word, then a clean fill.
        run_fill(32'h0000_1234, 2, -1);
        run_fill(32'hdead_beef, 0, 3);
        run_fill(32'h8000_0004, 1, -1);

        // inval and miss together: flush first, then the pending miss.
        @(posedge clk); #2;
        clear_mon();
        gap = 1; err_word = -1;
        bus.miss_addr = 32'h0040_07e0;
        bus.miss = 1'b1; bus.inval = 1'b1;
        wait_done(NrLines + 20, ok);
        check_eq("combo_flush_done_seen", ok, 1);
        @(posedge clk); #2;
        bus.inval = 1'b0;
        check_flush();
        clear_mon();
        finish_fill(32'h0040_07e0, 1, -1);

        // Reset in the middle of a fill, then an invalidate.
        @(posedge clk); #2;
        clear_mon();
        gap = 0; err_word = -1;
        bus.miss_addr = 32'h1234_5678;
        bus.miss = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ack_idx >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("midfill_acks_seen", ok, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midfill_reset");
        bus.miss = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_flush();

        // Randomized fills with occasional errors and invalidates.
        for (int it = 0; it < 14; it++) begin
            a = $urandom;
            if (it % 6 == 5) begin
                run_flush();
            end else if ($urandom_range(0, 2) == 0) begin
                run_fill(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            end else begin
                run_fill(a, int'($urandom_range(0, 3)), -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Sequences line fills and whole-cache invalidation for a direct-mapped cache built from a byte-lane data RAM plus a separate tag/valid RAM.
- On a miss it fetches one full line from the memory bus, one word at a time, writes each word into the data RAM, then commits the tag with valid=1.
- On an invalidate request it walks every tag index and clears valid.
- Sits between the cache lookup logic (requester) and the memory bus master port.

Parameters:
- cache_size, 8192, total data bytes.
- cache_line_size, 32, bytes per line; power of two, at least 8.
- Derived localparams:
  - words_per_line = cache_line_size/4
  - nr_lines = cache_size/cache_line_size
  - data_addr_bits = clog2(cache_size/4)
  - index_bits = clog2(nr_lines)
  - offset_bits = clog2(cache_line_size)
  - tag_bits = 32 - index_bits - offset_bits

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss  in  1  fill request; held by requester until done.
- miss_addr  in  32  byte address of the missing access.
- inval  in  1  invalidate-all request; held until done.
- busy  out  1  controller not idle.
- done  out  1  one-cycle pulse; fill or invalidate finished.
- fill_error  out  1  one-cycle pulse with done when a fill aborted on bus error.
- m_access  out  1  memory bus request.
- m_addr  out  32  word-aligned bus address.
- m_ack  in  1  bus word complete.
- m_error  in  1  bus error; qualified by m_ack.
- m_data  in  32  bus read data; valid with m_ack.
- dram_wr_en  out  1  data RAM write strobe.
- dram_write_addr  out  data_addr_bits  data RAM word index.
- dram_write_data  out  32  data RAM write data.
- dram_bytesel  out  4  byte lanes; always 4'hf when dram_wr_en.
- tag_wr_en  out  1  tag RAM write strobe.
- tag_index  out  index_bits  tag RAM index.
- tag_value  out  tag_bits  tag to store.
- tag_valid  out  1  valid bit to store.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State IDLE; word counter = 0; flush counter = 0.
  - All outputs 0 (busy, done, fill_error, m_access, m_addr, dram_*, tag_*).
  - Reset mid-fill or mid-flush abandons the operation. Tag contents are then undefined; software must issue inval.
- States: IDLE, FILL, COMMIT, FLUSH.
- IDLE:
  - inval high → FLUSH.
  - Otherwise miss high → FILL; latch line base = {miss_addr[31:offset_bits], zeros}.
  - inval has priority when inval and miss are both high; miss stays pending.
  - Requests while busy are ignored, not queued.
- FILL entry cycle:
  - tag_wr_en=1, tag_valid=0, tag_index = line index, so a partial line never hits.
  - m_access=1, m_addr=line base.
- FILL:
  - m_access stays high continuously; each m_ack completes the word at the current m_addr.
  - On m_ack without m_error:
    - Next cycle: dram_wr_en=1, dram_write_addr={index, word counter}, dram_write_data=registered m_data.
    - Word counter +1; m_addr += 4.
  - Data RAM writes are registered, one cycle after the ack.
  - On the ack of word words_per_line-1 → COMMIT, m_access drops the next cycle.
  - On m_ack with m_error:
    - Deassert m_access; no data RAM write for that word.
    - Next cycle done=1, fill_error=1, return to IDLE; tag stays invalid.
- COMMIT (one cycle):
  - Last data word is written: dram_wr_en=1.
  - tag_wr_en=1, tag_valid=1, tag_value=miss tag.
  - done=1; next state IDLE.
- FLUSH:
  - One tag write per cycle: tag_wr_en=1, tag_valid=0, tag_index = flush counter 0..nr_lines-1.
  - done=1 in the cycle the last index is written, then IDLE.
  - Takes exactly nr_lines cycles.
- busy=1 in every non-IDLE state.
- Counter wrap: the word counter wraps to 0 on fill completion; the flush counter resets to 0 on exit.
- Ack latency of the bus is arbitrary, 1..N cycles. Back-to-back acks give one data RAM write per cycle.
- done pulse and busy deassert coincide with the return to IDLE (busy low the cycle after done).

Test Plan:
- Reset: hold rst_n low, drive miss=1 → all outputs 0. Release → fill begins the cycle after the first sampled miss.
- Fill with zero-wait acks, miss_addr=0x0000_1234 → tag write valid=0 at index 0x91. Then m_addr 0x1220..0x123c. dram addresses 0x488..0x48f with m_data 0xA0..0xA7. COMMIT tag 0x0, valid=1, done once. Total 10 cycles busy.
- Fill with 3-cycle ack latency → m_addr holds until each ack; exactly 8 dram writes, each data matches the ack cycle's m_data.
- m_error on the 4th ack → 3 dram writes only, fill_error=1 and done=1 same cycle, no valid=1 tag write, next miss accepted.
- miss and inval asserted together in IDLE → FLUSH runs 256 cycles, indices 0..255, valid=0. Then miss is serviced.
- rst_n pulsed low mid-FILL after 2 acks → outputs 0 immediately, state IDLE. Subsequent inval completes normally.
